ipm_distributed_shiftregister_dyn_v1_3: RTL

IPM_DISTRIBUTED_SHIFTREGISTER_DYN_V1_3 -- requirements
Module: ipm_distributed_shiftregister_dyn_v1_3

---
 rtl/ipm_distributed_shiftregister_dyn_v1_3.sv | 115 +++++++++++
 1 files changed

// File: rtl/ipm_distributed_shiftregister_dyn_v1_3.sv
// ipm_distributed_shiftregister_dyn_v1_3
//
// Variable-depth delay line built on a circular distributed-RAM buffer.
// Every enabled clock edge writes din at the write pointer and advances it.
// The read tap sits eaddr words behind the write pointer, where
// eaddr = min(addr, VARIABLE_MAX_DEPTH-1). A fill counter tracks how many
// words have been written since reset, so o_valid only rises once the
// selected tap points at a word written after reset.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : asynchronous active-low reset
//   i_aclken : clock enable; nothing changes while low
//   din      : write-end data (DATA_WIDTH)
//   addr     : read tap select, delay = addr+1 enabled edges (ADDR_WIDTH)
//   dout     : read-end data (DATA_WIDTH)
//   o_valid  : dout holds a word written since reset
//
// Stream semantics: there is no backpressure. Each enabled edge is one
// transfer in (din) and one transfer out (dout/o_valid); o_valid qualifies
// dout and is the only indication that dout carries real data.
module ipm_distributed_shiftregister_dyn_v1_3 #(
  parameter  int VARIABLE_MAX_DEPTH = 16,
  parameter  int DATA_WIDTH         = 1,
  parameter  int OUT_REG            = 0,
  localparam int ADDR_WIDTH = (VARIABLE_MAX_DEPTH <= 16)  ? 4 :
                              (VARIABLE_MAX_DEPTH <= 32)  ? 5 :
                              (VARIABLE_MAX_DEPTH <= 64)  ? 6 :
                              (VARIABLE_MAX_DEPTH <= 128) ? 7 :
                              (VARIABLE_MAX_DEPTH <= 256) ? 8 :
                              (VARIABLE_MAX_DEPTH <= 512) ? 9 : 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_aclken,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  o_valid
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
  // The fill counter must be able to hold VARIABLE_MAX_DEPTH itself.
  localparam int CNT_WIDTH = $clog2(VARIABLE_MAX_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_TAP = ADDR_WIDTH'(VARIABLE_MAX_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = CNT_WIDTH'(VARIABLE_MAX_DEPTH);

  // Storage is deliberately not reset so it maps onto distributed RAM.
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [CNT_WIDTH-1:0]  fcnt_q, fcnt_d;
  logic [DATA_WIDTH-1:0] tap_q, tap_d;
  logic                  tap_vld_q, tap_vld_d;
  logic [ADDR_WIDTH-1:0] eaddr;
  logic [ADDR_WIDTH-1:0] rptr;

  always_comb begin
    eaddr  = (addr > MAX_TAP) ? MAX_TAP : addr;
    // Natural modulo-2^ADDR_WIDTH wrap of the subtraction gives the tap.
    rptr   = wptr_q - eaddr;
    wptr_d = wptr_q + ADDR_WIDTH'(1);
    fcnt_d = (fcnt_q == CNT_MAX) ? fcnt_q : fcnt_q + CNT_WIDTH'(1);
    // Tap 0 is a one-register delay; the RAM word at wptr has not been
    // written yet on this edge, so bypass straight from din.
    tap_d  = (eaddr == '0) ? din : mem_q[rptr];
    // fcnt+1 > eaddr, written without the +1 to avoid overflow concerns.
    tap_vld_d = (32'(fcnt_q) >= 32'(eaddr));
  end

  // RAM write; the read above sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (i_aclken) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      fcnt_q    <= '0;
      tap_q     <= '0;
      tap_vld_q <= 1'b0;
    end else if (i_aclken) begin
      wptr_q    <= wptr_d;
      fcnt_q    <= fcnt_d;
      tap_q     <= tap_d;
      tap_vld_q <= tap_vld_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_q;
      logic                  out_vld_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_q     <= '0;
          out_vld_q <= 1'b0;
        end else if (i_aclken) begin
          out_q     <= tap_q;
          out_vld_q <= tap_vld_q;
        end
      end

      assign dout    = out_q;
      assign o_valid = out_vld_q;
    end else begin : g_no_out_reg
      assign dout    = tap_q;
      assign o_valid = tap_vld_q;
    end
  endgenerate

endmodule
